// File: rtl/mu0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mu0_pkg
// Description : Shared MU0 constants and boot-arbiter FSM state encoding.
//               The ERROR state exists only when MU0_BOOT_CHECKSUM_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
package mu0_pkg;

  localparam int   c_addr_w    = 12;
  localparam int   c_data_w    = 16;
  localparam int   c_opc_w     = 4;

  localparam logic c_rnw_read  = 1'b1;
  localparam logic c_rnw_write = 1'b0;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_RUN   = 3'd3
`ifdef MU0_BOOT_CHECKSUM_EN
    ,
    ST_ERROR = 3'd4
`endif
  } boot_state_t;

endpackage
`default_nettype wire

// File: rtl/mu0_boot_writer.sv
`default_nettype none
// ============================================================================
// Module      : mu0_boot_writer
// Description : Registered write stage for boot loads. Drops beats whose
//               address is outside memory (raising a sticky error) and counts
//               the words actually written, saturating at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module mu0_boot_writer
  import mu0_pkg::*;
#(
  parameter int MEM_DEPTH = 32,
  parameter int CNT_W     = $clog2(MEM_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                beat,
  input  logic [c_addr_w-1:0] addr,
  input  logic [c_data_w-1:0] data,
  output logic                wr_valid,
  output logic [c_addr_w-1:0] wr_addr,
  output logic [c_data_w-1:0] wr_data,
  output logic [CNT_W-1:0]    words_loaded,
  output logic                addr_err
);

  logic                r_wr_valid;
  logic [c_addr_w-1:0] r_wr_addr;
  logic [c_data_w-1:0] r_wr_data;
  logic [CNT_W-1:0]    r_words;
  logic                r_addr_err;
  logic                w_in_range;

  assign w_in_range = (32'(addr) < MEM_DEPTH);

  // Capture beats into the write stage and update the counter / error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_words    <= '0;
      r_addr_err <= 1'b0;
    end else if (clear) begin
      r_wr_valid <= 1'b0;
      r_words    <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_wr_valid <= beat && w_in_range;
      if (beat) begin
        r_wr_addr <= addr;
        r_wr_data <= data;
      end
      if (beat && w_in_range && (r_words != '1)) begin
        r_words <= r_words + 1'b1;
      end
      if (beat && !w_in_range) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  // An idle stage presents zero address and data to memory.
  assign wr_valid     = r_wr_valid;
  assign wr_addr      = r_wr_valid ? r_wr_addr : '0;
  assign wr_data      = r_wr_valid ? r_wr_data : '0;
  assign words_loaded = r_words;
  assign addr_err     = r_addr_err;

endmodule
`default_nettype wire

// File: rtl/mu0_boot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mu0_boot_arbiter
// Description : Owns the MU0 memory port. Loads an image from a valid/ready
//               stream while holding the core in reset, then releases the
//               core and hands the port over. Optional feature macro:
//               MU0_BOOT_CHECKSUM_EN (last beat carries a 16-bit sum check).
// Revision    : 1.0 - initial release
// ============================================================================
module mu0_boot_arbiter
  import mu0_pkg::*;
#(
  parameter int MEM_DEPTH  = 32,
  parameter int RESET_HOLD = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [c_addr_w-1:0]            load_addr,
  input  logic [c_data_w-1:0]            load_data,
  input  logic                           load_last,
  input  logic                           reload,
  output logic                           cpu_rst_n,
  input  logic [c_addr_w-1:0]            cpu_addr,
  input  logic [c_data_w-1:0]            cpu_wdata,
  input  logic                           cpu_memrq,
  input  logic                           cpu_rnw,
  output logic [c_addr_w-1:0]            mem_addr,
  output logic [c_data_w-1:0]            mem_wdata,
  output logic                           mem_memrq,
  output logic                           mem_rnw,
  output logic                           boot_done,
  output logic [$clog2(MEM_DEPTH):0]     words_loaded,
  output logic                           addr_err
);

  localparam int                  c_cnt_w     = $clog2(MEM_DEPTH) + 1;
  localparam int                  c_hold_w    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [c_hold_w-1:0] c_hold_init = c_hold_w'(RESET_HOLD - 1);

  boot_state_t         r_state;
  boot_state_t         w_state_nxt;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [c_hold_w-1:0] w_hold_nxt;
  logic                r_started;
  logic                w_accept;
  logic                w_reload;
  logic                w_beat;
  logic                w_wr_valid;
  logic [c_addr_w-1:0] w_wr_addr;
  logic [c_data_w-1:0] w_wr_data;

  // load_ready stays low for the first cycle after reset is released.
  assign load_ready = r_started && (r_state == ST_BOOT);
  assign w_accept   = load_valid && load_ready;
  assign w_reload   = reload && (r_state != ST_BOOT);
  assign cpu_rst_n  = (r_state == ST_RUN);
  assign boot_done  = (r_state == ST_RUN);

`ifdef MU0_BOOT_CHECKSUM_EN
  logic [c_data_w-1:0] r_sum;
  logic                r_sum_ok;

  // The last beat carries the expected sum and is never written.
  assign w_beat = w_accept && !load_last;

  // Accumulate the image sum and latch the comparison on the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum    <= '0;
      r_sum_ok <= 1'b0;
    end else if (w_reload) begin
      r_sum    <= '0;
      r_sum_ok <= 1'b0;
    end else if (w_accept) begin
      if (load_last) begin
        r_sum_ok <= (r_sum == load_data);
      end else begin
        r_sum <= r_sum + load_data;
      end
    end
  end
`else
  assign w_beat = w_accept;
`endif

  // State, hold counter and the one-cycle-late load_ready enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_hold_cnt <= '0;
      r_started  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_started  <= 1'b1;
    end
  end

  // Next-state logic; reload overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    if (w_reload) begin
      w_state_nxt = ST_BOOT;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (w_accept && load_last) w_state_nxt = ST_FLUSH;
        end
        ST_FLUSH: begin
          w_hold_nxt  = c_hold_init;
          w_state_nxt = ST_HOLD;
`ifdef MU0_BOOT_CHECKSUM_EN
          if (!r_sum_ok) w_state_nxt = ST_ERROR;
`endif
        end
        ST_HOLD: begin
          if (r_hold_cnt == '0) w_state_nxt = ST_RUN;
          else                  w_hold_nxt  = r_hold_cnt - 1'b1;
        end
        ST_RUN: begin
          w_state_nxt = ST_RUN;
        end
`ifdef MU0_BOOT_CHECKSUM_EN
        ST_ERROR: begin
          w_state_nxt = ST_ERROR;
        end
`endif
        default: begin
          w_state_nxt = ST_BOOT;
        end
      endcase
    end
  end

  mu0_boot_writer #(
    .MEM_DEPTH (MEM_DEPTH),
    .CNT_W     (c_cnt_w)
  ) u_writer (
    .clk          (clk),
    .rst          (rst),
    .clear        (w_reload),
    .beat         (w_beat),
    .addr         (load_addr),
    .data         (load_data),
    .wr_valid     (w_wr_valid),
    .wr_addr      (w_wr_addr),
    .wr_data      (w_wr_data),
    .words_loaded (words_loaded),
    .addr_err     (addr_err)
  );

  // Memory port mux: core owns the port in RUN, the write stage otherwise.
  always_comb begin
    mem_addr  = w_wr_addr;
    mem_wdata = w_wr_data;
    mem_memrq = w_wr_valid;
    mem_rnw   = w_wr_valid ? c_rnw_write : c_rnw_read;
    if (r_state == ST_RUN) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_memrq = cpu_memrq;
      mem_rnw   = cpu_rnw;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mu0_boot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mu0_boot_arbiter
// Description : Self-checking bench for mu0_boot_arbiter. Expected memory
//               writes are queued as beats are accepted and compared as the
//               write stage drives the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mu0_boot_arbiter;
  import mu0_pkg::*;

  localparam int MEM_DEPTH  = 32;
  localparam int RESET_HOLD = 4;
  localparam int CNT_W      = $clog2(MEM_DEPTH) + 1;

  logic                clk        = 1'b0;
  logic                rst        = 1'b1;
  logic                load_valid = 1'b0;
  logic                load_ready;
  logic [c_addr_w-1:0] load_addr  = '0;
  logic [c_data_w-1:0] load_data  = '0;
  logic                load_last  = 1'b0;
  logic                reload     = 1'b0;
  logic                cpu_rst_n;
  logic [c_addr_w-1:0] cpu_addr   = '0;
  logic [c_data_w-1:0] cpu_wdata  = '0;
  logic                cpu_memrq  = 1'b0;
  logic                cpu_rnw    = 1'b1;
  logic [c_addr_w-1:0] mem_addr;
  logic [c_data_w-1:0] mem_wdata;
  logic                mem_memrq;
  logic                mem_rnw;
  logic                boot_done;
  logic [CNT_W-1:0]    words_loaded;
  logic                addr_err;

  typedef struct packed {
    logic [c_addr_w-1:0] addr;
    logic [c_data_w-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [15:0]   tb_mem [0:MEM_DEPTH-1];
  logic [15:0]   img1   [0:20];
  int            n_checks = 0;
  int            n_pass   = 0;

  mu0_boot_arbiter #(
    .MEM_DEPTH  (MEM_DEPTH),
    .RESET_HOLD (RESET_HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_last    (load_last),
    .reload       (reload),
    .cpu_rst_n    (cpu_rst_n),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_memrq    (cpu_memrq),
    .cpu_rnw      (cpu_rnw),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_memrq    (mem_memrq),
    .mem_rnw      (mem_rnw),
    .boot_done    (boot_done),
    .words_loaded (words_loaded),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Memory model and scoreboard consumer for boot-time writes.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && !boot_done && mem_memrq && (mem_rnw == c_rnw_write)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", {20'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_addr", {20'd0, mem_addr}, {20'd0, e.addr});
        check_eq("wr_data", {16'd0, mem_wdata}, {16'd0, e.data});
      end
      if (32'(mem_addr) < MEM_DEPTH) tb_mem[mem_addr[4:0]] = mem_wdata;
    end
  end

  // Present one beat and hold it until accepted; queue its expected write.
  task automatic send(input logic [11:0] a, input logic [15:0] d, input logic last);
    int guard;
    bit wr;
    guard = 0;
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_last  = last;
    while (!load_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!load_ready) begin
      check_eq("send_timeout", 32'd0, 32'd1);
    end else begin
      wr = (32'(a) < MEM_DEPTH);
`ifdef MU0_BOOT_CHECKSUM_EN
      if (last) wr = 1'b0;
`endif
      if (wr) exp_q.push_back('{addr: a, data: d});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
    end
  endtask

  // Called right after the last beat is presented; counts cycles to RUN.
  task automatic wait_run(output int n);
    n = 0;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    check_eq("ready_drop", {31'd0, load_ready}, 32'd0);
    while (!cpu_rst_n && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, {31'd0, load_ready}, 32'd0);
    check_eq({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    check_eq({tag, "_boot_done"}, {31'd0, boot_done}, 32'd0);
    check_eq({tag, "_words"}, {26'd0, words_loaded}, 32'd0);
    check_eq({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
    check_eq({tag, "_memrq"}, {31'd0, mem_memrq}, 32'd0);
    check_eq({tag, "_rnw"}, {31'd0, mem_rnw}, 32'd1);
    check_eq({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
    check_eq({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
  endtask

  initial begin
    int n;
    int errs;
    logic [11:0] a2 [0:7];

    for (int i = 0; i < MEM_DEPTH; i++) tb_mem[i] = 16'h0000;
    for (int i = 0; i < 21; i++) img1[i] = 16'hA000 + 16'(i * 16'h0111);
    img1[18] = 16'h0000;

    // Reset values, then load_ready rises one edge after rst falls.
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    #1 check_eq("ready_before_edge", {31'd0, load_ready}, 32'd0);
    @(negedge clk);
    check_eq("ready_after_edge", {31'd0, load_ready}, 32'd1);

    // Image 1: 21 words, valid held high continuously.
    for (int i = 0; i < 21; i++) send(12'(i), img1[i], (i == 20));
    wait_run(n);
    check_eq("boot1_cycles", n, 1 + RESET_HOLD);
    check_eq("boot1_done", {31'd0, boot_done}, 32'd1);
    check_eq("boot1_words", {26'd0, words_loaded}, 32'd21);
    errs = 0;
    for (int i = 0; i < 21; i++) if (tb_mem[i] !== img1[i]) errs++;
    check_eq("boot1_image", errs, 0);

    // RUN: memory port follows the core combinationally.
    @(negedge clk);
    cpu_addr = 12'd18; cpu_wdata = 16'h0024; cpu_memrq = 1'b1; cpu_rnw = c_rnw_write;
    #1;
    check_eq("run_addr", {20'd0, mem_addr}, 32'd18);
    check_eq("run_wdata", {16'd0, mem_wdata}, 32'h0024);
    check_eq("run_memrq", {31'd0, mem_memrq}, 32'd1);
    check_eq("run_rnw_w", {31'd0, mem_rnw}, 32'd0);
    cpu_addr = 12'd5; cpu_rnw = c_rnw_read;
    #1;
    check_eq("run_addr2", {20'd0, mem_addr}, 32'd5);
    check_eq("run_rnw_r", {31'd0, mem_rnw}, 32'd1);
    @(negedge clk);
    cpu_addr = '0; cpu_wdata = '0; cpu_memrq = 1'b0; cpu_rnw = c_rnw_read;

    // Reload from RUN.
    pulse_reload();
    check_eq("reload_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check_eq("reload_ready", {31'd0, load_ready}, 32'd1);
    check_eq("reload_words", {26'd0, words_loaded}, 32'd0);

    // Image 2: toggled valid with one out-of-range beat (address 40).
    a2 = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd40, 12'd4, 12'd5, 12'd6};
    for (int i = 0; i < 8; i++) begin
      send(a2[i], 16'h5000 + 16'(i), (i == 7));
      if (i == 4) begin
        idle(1);
        check_eq("oob_addr_err", {31'd0, addr_err}, 32'd1);
        check_eq("oob_words", {26'd0, words_loaded}, 32'd4);
      end else if (i != 7) begin
        idle(1);
      end
    end
    wait_run(n);
    check_eq("boot2_cycles", n, 1 + RESET_HOLD);
    check_eq("boot2_words", {26'd0, words_loaded}, 32'd7);
    check_eq("boot2_addr_err", {31'd0, addr_err}, 32'd1);
    errs = 0;
    for (int i = 0; i < 8; i++)
      if (i != 4 && tb_mem[a2[i][4:0]] !== 16'h5000 + 16'(i)) errs++;
    for (int i = 7; i < 21; i++) if (tb_mem[i] !== img1[i]) errs++;
    check_eq("boot2_image", errs, 0);

    // Reload clears the sticky error and the counter.
    pulse_reload();
    check_eq("reload2_addr_err", {31'd0, addr_err}, 32'd0);
    check_eq("reload2_words", {26'd0, words_loaded}, 32'd0);

    // Asynchronous reset while in HOLD.
    for (int i = 0; i < 3; i++) send(12'(i), 16'h7000 + 16'(i), (i == 2));
    idle(3);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 check_reset_vals("hold_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send(12'(i), 16'h7100 + 16'(i), (i == 2));
    wait_run(n);
    check_eq("boot3_cycles", n, 1 + RESET_HOLD);
    check_eq("boot3_words", {26'd0, words_loaded}, 32'd3);
    check_eq("boot3_mem2", {16'd0, tb_mem[2]}, 32'h7102);

`ifdef MU0_BOOT_CHECKSUM_EN
    // Wrong checksum parks in ERROR; the correct one boots.
    pulse_reload();
    for (int i = 0; i < 3; i++) send(12'(i), 16'(i + 1), 1'b0);
    send(12'd3, 16'd7, 1'b1);
    idle(12);
    check_eq("chk_bad_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    check_eq("chk_bad_ready", {31'd0, load_ready}, 32'd0);
    check_eq("chk_bad_boot_done", {31'd0, boot_done}, 32'd0);
    pulse_reload();
    for (int i = 0; i < 3; i++) send(12'(i), 16'(i + 1), 1'b0);
    send(12'd3, 16'd6, 1'b1);
    wait_run(n);
    check_eq("chk_good_cycles", n, 1 + RESET_HOLD);
`endif

    idle(2);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
